// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 constants, round/schedule functions and FSM state type.
// Contents: state_e FSM encoding, IV default initial hash (H0 in [31:0]),
// K round-constant table, ror/big_s0/big_s1/sm_s0/sm_s1/ch/maj helpers.
package sha256_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} state_e;
    localparam logic [255:0] IV = 256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667;
    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
    endfunction
    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
    endfunction
    function automatic logic [31:0] sm_s0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] sm_s1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction
    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction
    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction
endpackage

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: 16-word sliding message-schedule window, one word per round.
// Ports: clk; load_i latches data_i (word t at [32t +: 32]); advance_i shifts the
// window by one word; w_o is W[t] for the current round.
module sha256_msg_sched (
    input  logic         clk,
    input  logic         load_i,
    input  logic         advance_i,
    input  logic [511:0] data_i,
    output logic [31:0]  w_o
);
    import sha256_pkg::*;
    logic [15:0][31:0] win_q;
    logic [31:0]       w_new;
    // win_q[0] holds W[t]; the appended word is W[t+16], valid for every t
    assign w_new = sm_s1(win_q[14]) + win_q[9] + sm_s0(win_q[1]) + win_q[0];
    assign w_o   = win_q[0];
    always_ff @(posedge clk) begin
        if (load_i) win_q <= data_i;
        else if (advance_i) win_q <= {w_new, win_q[15:1]};
    end
endmodule

// File: rtl/sha256_core.sv
// sha256_core: iterative single-block SHA-256 compression, one round per clock.
// Ports: clk; reset (sync, active-high); start_i requests a hash of data_in_i
// (sampled in IDLE/DONE); data_out_o digest with H0 in [31:0]; done_o level
// held until next accepted start; busy_o high during LOAD/ROUND/FINAL.
module sha256_core #(
    parameter logic [255:0] INIT_H = sha256_pkg::IV
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic [511:0] data_in_i,
    output logic [255:0] data_out_o,
    output logic         done_o,
    output logic         busy_o
);
    import sha256_pkg::*;
    state_e            state_q;
    logic [5:0]        t_q;
    logic [7:0][31:0]  v_q, v_d;
    logic [255:0]      data_out_q;
    logic              done_q, busy_q;
    logic [31:0]       w, t1, t2;
    sha256_msg_sched u_sched (
        .clk       (clk),
        .load_i    (state_q == LOAD),
        .advance_i (state_q == ROUND),
        .data_i    (data_in_i),
        .w_o       (w)
    );
    // v_q[0..7] = a..h
    assign t1  = v_q[7] + big_s1(v_q[4]) + ch(v_q[4], v_q[5], v_q[6]) + K[t_q] + w;
    assign t2  = big_s0(v_q[0]) + maj(v_q[0], v_q[1], v_q[2]);
    assign v_d = {v_q[6:4], 32'(v_q[3] + t1), v_q[2:0], 32'(t1 + t2)};
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            t_q        <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: if (start_i) begin
                    state_q <= LOAD;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b1;
                end
                LOAD: begin
                    v_q     <= INIT_H;
                    t_q     <= '0;
                    state_q <= ROUND;
                end
                ROUND: begin
                    v_q <= v_d;
                    t_q <= t_q + 6'd1;
                    if (t_q == 6'd63) state_q <= FINAL;
                end
                FINAL: begin
                    for (int i = 0; i < 8; i++) data_out_q[32*i +: 32] <= INIT_H[32*i +: 32] + v_q[i];
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign data_out_o = data_out_q;
    assign done_o     = done_q;
    assign busy_o     = busy_q;
endmodule
